// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall, branch flush and EX/MEM destination tags for the 5-stage pipeline
// Optional perf counters (stall_count, flush_count) enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
    parameter int ZR_REG       = 31,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_instruction,
    input  logic        reg_valid,
    input  logic        branch_taken,
    output logic        pc_write_en,
    output logic        ifreg_write_en,
    output logic        bubble,
    output logic        flush,
    output logic [4:0]  ex_rd,
    output logic        ex_wr,
    output logic [4:0]  mem_rd,
    output logic        mem_wr,
    output logic        mem_is_load
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH} state_t;

    localparam logic [4:0] ZR      = 5'(ZR_REG);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

    state_t      state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic        ex_ld;
    logic        use_rn, use_src2, dec_wr, dec_ld;
    logic [4:0]  rn, rd, src2;
    logic        src_match, load_use, lu_stall, take;
    logic        unused_bits;

    assign rn          = reg_instruction[9:5];
    assign rd          = reg_instruction[4:0];
    assign unused_bits = ^reg_instruction[15:10];

    always_comb begin
        use_rn   = 1'b0;
        use_src2 = 1'b0;
        src2     = reg_instruction[4:0];
        dec_wr   = 1'b0;
        dec_ld   = 1'b0;
        casez (reg_instruction[31:21])
            11'b10001010000, 11'b10001011000, 11'b10101011000,
            11'b11001010000, 11'b11101011000: begin
                use_rn   = 1'b1;
                use_src2 = 1'b1;
                src2     = reg_instruction[20:16];
                dec_wr   = 1'b1;
            end
            11'b11010011010, 11'b1001000100?: begin
                use_rn = 1'b1;
                dec_wr = 1'b1;
            end
            11'b11111000010: begin
                use_rn = 1'b1;
                dec_wr = 1'b1;
                dec_ld = 1'b1;
            end
            11'b11111000000: begin
                use_rn   = 1'b1;
                use_src2 = 1'b1;
            end
            11'b10110100???: use_src2 = 1'b1;
            default: ;
        endcase
    end

    // XZR reads are constant zero, so they never depend on a pending load
    assign src_match = (use_rn && rn != ZR && rn == ex_rd) ||
                       (use_src2 && src2 != ZR && src2 == ex_rd);
    assign load_use  = reg_valid && ex_ld && ex_wr && src_match;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        pc_write_en    = 1'b1;
        ifreg_write_en = 1'b1;
        bubble         = 1'b0;
        flush          = 1'b0;
        lu_stall       = 1'b0;
        if (!reset) begin
            case (state)
                RUN, LU_STALL: begin
                    // A taken branch outranks a stall: the stalled instruction is wrong-path
                    if (branch_taken) begin
                        flush      = 1'b1;
                        bubble     = 1'b1;
                        cnt_next   = FL_INIT;
                        state_next = (FL_INIT != 2'd0) ? BR_FLUSH : RUN;
                    end else if (load_use) begin
                        pc_write_en    = 1'b0;
                        ifreg_write_en = 1'b0;
                        bubble         = 1'b1;
                        lu_stall       = 1'b1;
                        state_next     = LU_STALL;
                    end else begin
                        state_next = RUN;
                    end
                end
                BR_FLUSH: begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                    if (cnt <= 2'd1) begin
                        cnt_next   = 2'd0;
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt - 2'd1;
                    end
                end
                default: begin
                    cnt_next   = 2'd0;
                    state_next = RUN;
                end
            endcase
        end
    end

    assign take = reg_valid && !bubble && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= 2'd0;
            ex_rd       <= 5'd0;
            ex_wr       <= 1'b0;
            ex_ld       <= 1'b0;
            mem_rd      <= 5'd0;
            mem_wr      <= 1'b0;
            mem_is_load <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mem_rd      <= ex_rd;
            mem_wr      <= ex_wr;
            mem_is_load <= ex_ld;
            ex_rd       <= take ? rd : 5'd0;
            ex_wr       <= take && dec_wr && (rd != ZR);
            ex_ld       <= take && dec_ld;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (lu_stall && !(&stall_count)) stall_count <= stall_count + 32'd1;
            if (flush && !(&flush_count))    flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit (FLUSH_CYCLES 1 and 3 instances)
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reg_instruction;
    logic        reg_valid;
    logic        branch_taken;
    logic        pc_write_en, ifreg_write_en, bubble, flush;
    logic [4:0]  ex_rd, mem_rd;
    logic        ex_wr, mem_wr, mem_is_load;
    logic        pc3, ifw3, bub3, fl3;
    logic [4:0]  ex_rd3, mem_rd3;
    logic        ex_wr3, mem_wr3, mem_ld3;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count, flush_count, stall_count3, flush_count3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.ZR_REG(31), .FLUSH_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .reg_instruction(reg_instruction),
        .reg_valid(reg_valid), .branch_taken(branch_taken),
        .pc_write_en(pc_write_en), .ifreg_write_en(ifreg_write_en),
        .bubble(bubble), .flush(flush), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_is_load(mem_is_load)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    hazard_stall_unit #(.ZR_REG(31), .FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .reg_instruction(reg_instruction),
        .reg_valid(reg_valid), .branch_taken(branch_taken),
        .pc_write_en(pc3), .ifreg_write_en(ifw3),
        .bubble(bub3), .flush(fl3), .ex_rd(ex_rd3), .ex_wr(ex_wr3),
        .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_is_load(mem_ld3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(stall_count3), .flush_count(flush_count3)
`endif
    );

    typedef struct {
        logic       stall;
        logic       bub;
        logic       fl;
        logic       fl3;
        logic [4:0] exrd;
        logic       exwr;
        logic [4:0] memrd;
        logic       memwr;
        logic       memld;
        logic       rdall;
    } exp_t;

    exp_t q[$];
    exp_t e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic st, input logic bu, input logic fl, input logic f3,
                                input logic [4:0] er, input logic ew,
                                input logic [4:0] mr, input logic mw, input logic ml);
        exp_t r;
        r.stall = st; r.bub = bu; r.fl = fl; r.fl3 = f3;
        r.exrd = er; r.exwr = ew; r.memrd = mr; r.memwr = mw; r.memld = ml;
        r.rdall = 1'b0;
        return r;
    endfunction

    function automatic exp_t mk_rst();
        exp_t r;
        r = mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
        r.rdall = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] ldur(input logic [4:0] rt, input logic [4:0] rn);
        return {11'b11111000010, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] stur(input logic [4:0] rt, input logic [4:0] rn);
        return {11'b11111000000, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'b10001011000, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] cbz(input logic [4:0] rt);
        return {8'b10110100, 19'd0, rt};
    endfunction
    function automatic logic [31:0] b_ins();
        return {6'b000101, 26'd0};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic br);
        reg_instruction = ins;
        reg_valid       = v;
        branch_taken    = br;
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic br, input exp_t x);
        @(posedge clk);
        #1;
        drive(ins, v, br);
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_write_en",    pc_write_en,    !e.stall);
            check("ifreg_write_en", ifreg_write_en, !e.stall);
            check("bubble",         bubble,         e.bub);
            check("flush",          flush,          e.fl);
            check("flush_fc3",      fl3,            e.fl3);
            check("ex_wr",          ex_wr,          e.exwr);
            check("mem_wr",         mem_wr,         e.memwr);
            check("mem_is_load",    mem_is_load,    e.memld);
            if (e.exwr || e.rdall)  check("ex_rd",  ex_rd,  e.exrd);
            if (e.memwr || e.rdall) check("mem_rd", mem_rd, e.memrd);
        end
    end

    initial begin
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(ldur(1, 2), 1'b1, 1'b1);
        q.push_back(mk_rst());
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'd0, 1'b0, 1'b0);
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // load-use on Rn: one stall cycle, then ADD proceeds
        step(ldur(1, 2),    1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(add(3, 1, 4),  1, 0, mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
        step(add(3, 1, 4),  1, 0, mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 0, 0, 3, 1, 0));
        // XZR destination / sources never hazard
        step(ldur(31, 2),   1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(add(3, 31, 31),1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 3, 1, 0, 0, 1));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 0, 0, 3, 1, 0));
        // CBZ Rt and STUR Rt sources stall, B does not
        step(ldur(5, 2),    1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(cbz(5),        1, 0, mk(1, 1, 0, 0, 5, 1, 0, 0, 0));
        step(cbz(5),        1, 0, mk(0, 0, 0, 0, 0, 0, 5, 1, 1));
        step(ldur(5, 2),    1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(stur(5, 6),    1, 0, mk(1, 1, 0, 0, 5, 1, 0, 0, 0));
        step(stur(5, 6),    1, 0, mk(0, 0, 0, 0, 0, 0, 5, 1, 1));
        step(ldur(5, 2),    1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(b_ins(),       1, 0, mk(0, 0, 0, 0, 5, 1, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 0, 0, 5, 1, 1));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // branch together with load-use: flush wins, no stall
        step(ldur(1, 2),    1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(add(3, 1, 4),  1, 1, mk(0, 1, 1, 1, 1, 1, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 1, 0, 0, 1, 1, 1));
        step(32'd0,         0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // plain branch pulse: 1 vs 3 flush cycles
        step(32'd0,         0, 1, mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        step(32'd0,         0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // async reset while in LU_STALL
        step(ldur(1, 2),    1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(add(3, 1, 4),  1, 0, mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(add(3, 1, 4), 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        q.push_back(mk_rst());
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(ldur(7, 2), 1'b1, 1'b0);
        q.push_back(mk_rst());
        step(add(8, 7, 9),  1, 0, mk(1, 1, 0, 0, 7, 1, 0, 0, 0));
        step(add(8, 7, 9),  1, 0, mk(0, 0, 0, 0, 0, 0, 7, 1, 1));

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_count", stall_count, 32'd1);
        check("flush_count", flush_count, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side companion to the forwarding unit in the 5-stage ARM-subset pipeline (IF, REG, EX, MEM, WB).
- Decodes the instruction in REG and tracks its destination metadata through EX and MEM.
- Detects load-use hazards and resolves them by stalling one cycle and inserting a bubble.
- Flushes on taken branches, and publishes per-stage destination/valid tags that the forwarding unit consumes.

Parameters:
- ZR_REG, 31: register index that never creates a hazard (XZR).
- FLUSH_CYCLES, 1: bubble cycles inserted after a taken branch (1..3).

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high
- reg_instruction  input  32  instruction currently in REG stage
- reg_valid  input  1  REG-stage instruction is real (not a bubble)
- branch_taken  input  1  taken branch or CBZ resolved in EX this cycle
- pc_write_en  output  1  PC may advance
- ifreg_write_en  output  1  IF/REG pipeline register may load
- bubble  output  1  load NOP into REG/EX register instead of the REG instruction
- flush  output  1  invalidate the IF/REG register
- ex_rd  output  5  destination of the EX-stage instruction
- ex_wr  output  1  EX-stage instruction writes a register (R/I/LDUR, rd != ZR_REG)
- mem_rd  output  5  destination of the MEM-stage instruction
- mem_wr  output  1  MEM-stage instruction writes a register
- mem_is_load  output  1  MEM-stage instruction is LDUR

Behaviour:
- Decode of reg_instruction[31:21]:
  - R-type (10001010000, 10001011000, 10101011000, 11001010000, 11101011000): sources Rn[9:5] and Rm[20:16]; writes Rd[4:0].
  - LSR (11010011010), I-type (1001000100X): source Rn; writes Rd.
  - LDUR (11111000010): source Rn; writes Rd; is_load = 1.
  - STUR (11111000000): sources Rn and Rt[4:0]; no write.
  - CBZ (10110100XXX): source Rt[4:0]; no write.
  - B (000101XXXXX), B.cond (01010100XXX), any other opcode: no sources, no write.
  - A source equal to ZR_REG never matches.
- Stage metadata registers EX{rd, wr, ld} and MEM{rd, wr, ld}:
  - Each clock edge: MEM <= EX.
  - EX <= decoded REG info when reg_valid and neither bubble nor flush; otherwise EX <= zero (wr = 0, ld = 0).
- Load-use hazard (combinational): reg_valid && EX.ld && EX.wr && EX.rd matches any REG source.
- FSM states: RUN, LU_STALL, BR_FLUSH.
  - RUN: defaults pc_write_en = 1, ifreg_write_en = 1, bubble = 0, flush = 0.
  - RUN with branch_taken: flush = 1, bubble = 1, load counter with FLUSH_CYCLES-1; go to BR_FLUSH if the counter is nonzero, else stay in RUN.
  - RUN with load-use (no branch_taken): pc_write_en = 0, ifreg_write_en = 0, bubble = 1; go to LU_STALL.
  - LU_STALL: lasts exactly one cycle (the load is now in MEM and forwarding covers it). Hazard is re-evaluated; a second consecutive stall is legal only if a new load sits in EX, which cannot happen while bubbling. Return to RUN.
  - BR_FLUSH: flush = 1, bubble = 1, decrement counter; return to RUN at 0.
- Simultaneous branch_taken and load-use: branch wins. Flush, no stall; the stalled instruction is on the wrong path anyway.
- All outputs derive from state plus current inputs. The metadata outputs are registered with zero latency from the metadata registers.
- Reset (asynchronous, any time including mid-stall or mid-flush): state = RUN, counter = 0, EX and MEM metadata = 0. Outputs during reset: pc_write_en = 1, ifreg_write_en = 1, bubble = 0, flush = 0, ex_rd = mem_rd = 0, ex_wr = mem_wr = mem_is_load = 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_count [31:0] and flush_count [31:0].
  - stall_count increments on each cycle with bubble = 1 caused by load-use.
  - flush_count increments on each flush cycle.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- LDUR X1,[X2,#0] in REG, then ADD X3,X1,X4 in REG next cycle -> exactly one cycle of pc_write_en = 0, ifreg_write_en = 0, bubble = 1. Then mem_rd = 1, mem_is_load = 1, and ADD proceeds with ex_rd = 3, ex_wr = 1.
- LDUR X31,[X2,#0] followed by ADD X3,X31,X31 -> no stall; ex_wr = 0 for the load.
- LDUR X5,... followed by CBZ X5 -> one-cycle stall; followed by STUR X5,[X6] (Rt match) -> one-cycle stall; followed by B -> no stall.
- branch_taken in the same cycle as a load-use match, FLUSH_CYCLES = 1 -> flush = 1, bubble = 1, pc_write_en = 1, no stall; next cycle back to RUN.
- FLUSH_CYCLES = 3, branch_taken pulsed -> flush high for 3 consecutive cycles, then RUN.
- reset asserted asynchronously during LU_STALL -> outputs immediately at reset values; after release, first instruction decodes normally with EX/MEM metadata zero.
